// File: rtl/z80_memctl.sv
// z80_memctl: byte RAM responder for the z80 bus with a pipelined read path,
// CPU HOLD control and a streaming loader that fills RAM while the CPU is held.
module z80_memctl #(
    parameter int ADDR_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [15:0] A,
    input  logic [7:0]  DO,
    input  logic        W,
    output logic [7:0]  DI,
    output logic        HOLD,
    input  logic        LD_START,
    input  logic [15:0] LD_ADDR,
    input  logic        LD_VALID,
    input  logic [7:0]  LD_DATA,
    input  logic        LD_LAST,
    output logic        LD_READY,
    input  logic        GO
);
    typedef enum logic [1:0] {
        HALTED,
        LOAD,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH-1:0] ptr_nxt;
    logic [7:0]            mem [2**ADDR_WIDTH];
    logic [7:0]            pipe [LATENCY];

    logic                  accept;
    logic                  cpu_wr;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [7:0]            wr_data;
    logic [7:0]            rd_data;

    // Loader and CPU writes live in disjoint states, so one port suffices.
    assign accept  = (state == LOAD) && LD_VALID;
    assign cpu_wr  = (state == RUN) && W;
    assign wr_en   = RESET_N && (accept || cpu_wr);
    assign wr_addr = accept ? ptr : A[ADDR_WIDTH-1:0];
    assign wr_data = accept ? LD_DATA : DO;
    assign rd_addr = A[ADDR_WIDTH-1:0];

    // Write-first: a same-edge write to the read address bypasses the array.
    assign rd_data = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (accept) begin
            ptr_nxt = ptr + 1'b1;
        end
        if (LD_START) begin
            state_nxt = LOAD;
            ptr_nxt   = LD_ADDR[ADDR_WIDTH-1:0];
        end else if ((state == HALTED) && GO) begin
            state_nxt = RUN;
        end else if (accept && LD_LAST) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state    <= HALTED;
            ptr      <= '0;
            HOLD     <= 1'b0;
            LD_READY <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            HOLD     <= (state_nxt == RUN);
            LD_READY <= (state_nxt == LOAD);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe[i] <= 8'h00;
            end
        end else begin
            pipe[0] <= rd_data;
            for (int i = 1; i < LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign DI = pipe[LATENCY-1];

endmodule

// File: tb/tb_z80_memctl.sv
// Bench for z80_memctl: four instances (LATENCY 1..4) share one stimulus
// stream and are compared every cycle against a byte-array reference model.
module tb_z80_memctl;
    localparam int S_HALT = 0;
    localparam int S_LOAD = 1;
    localparam int S_RUN  = 2;

    logic        CLOCK;
    logic        RESET_N;
    logic [15:0] A;
    logic [7:0]  DO;
    logic        W;
    logic        LD_START;
    logic [15:0] LD_ADDR;
    logic        LD_VALID;
    logic [7:0]  LD_DATA;
    logic        LD_LAST;
    logic        GO;

    logic [3:0][7:0] di;
    logic [3:0]      hold_v;
    logic [3:0]      rdy_v;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        z80_memctl #(
            .ADDR_WIDTH(16),
            .LATENCY   (g + 1)
        ) u_dut (
            .CLOCK   (CLOCK),
            .RESET_N (RESET_N),
            .A       (A),
            .DO      (DO),
            .W       (W),
            .DI      (di[g]),
            .HOLD    (hold_v[g]),
            .LD_START(LD_START),
            .LD_ADDR (LD_ADDR),
            .LD_VALID(LD_VALID),
            .LD_DATA (LD_DATA),
            .LD_LAST (LD_LAST),
            .LD_READY(rdy_v[g]),
            .GO      (GO)
        );
    end

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain byte array, a history of read results and a mode.
    logic [7:0] mm [65536];
    bit         mk [65536];
    logic [7:0] hv [4];
    bit         hk [4];
    int         m_state = S_HALT;
    int         m_ptr   = 0;
    bit         acc;

    always @(posedge CLOCK) begin
        if (!RESET_N) begin
            m_state = S_HALT;
            m_ptr   = 0;
            for (int g = 0; g < 4; g++) begin
                hv[g] = 8'h00;
                hk[g] = 1'b1;
            end
        end else begin
            acc = (m_state == S_LOAD) && LD_VALID;
            if (acc) begin
                mm[m_ptr] = LD_DATA;
                mk[m_ptr] = 1'b1;
            end
            if ((m_state == S_RUN) && W) begin
                mm[A] = DO;
                mk[A] = 1'b1;
            end
            for (int g = 3; g > 0; g--) begin
                hv[g] = hv[g-1];
                hk[g] = hk[g-1];
            end
            hv[0] = mm[A];
            hk[0] = mk[A];
            if (LD_START) begin
                m_state = S_LOAD;
                m_ptr   = int'(LD_ADDR);
            end else begin
                if (acc) m_ptr = (m_ptr + 1) % 65536;
                if ((m_state == S_HALT) && GO) m_state = S_RUN;
                else if (acc && LD_LAST) m_state = S_RUN;
            end
        end
    end

    always @(negedge CLOCK) begin
        if (check_en) begin
            for (int g = 0; g < 4; g++) begin
                chk($sformatf("hold_L%0d", g + 1), {7'b0, hold_v[g]},
                    {7'b0, m_state == S_RUN});
                chk($sformatf("ready_L%0d", g + 1), {7'b0, rdy_v[g]},
                    {7'b0, m_state == S_LOAD});
                if (hk[g]) chk($sformatf("di_L%0d", g + 1), di[g], hv[g]);
            end
        end
    end

    task automatic step();
        @(negedge CLOCK);
    endtask

    task automatic idle();
        A = 16'h0; DO = 8'h0; W = 0; LD_START = 0; LD_ADDR = 16'h0;
        LD_VALID = 0; LD_DATA = 8'h0; LD_LAST = 0; GO = 0;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        LD_VALID = 1; LD_DATA = d; LD_LAST = last;
        step();
        LD_VALID = 0; LD_LAST = 0;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0: return 16'h0100 + 16'($urandom_range(0, 15));
            1: return 16'h2000 + 16'($urandom_range(0, 7));
            2: return 16'h0000 + 16'($urandom_range(0, 7));
            default: return 16'hFFF8 + 16'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        idle();
        RESET_N = 0;
        repeat (3) step();
        RESET_N = 1;
        check_en = 1;
        chk("rst_di", di[1], 8'h00);
        chk("rst_hold", {7'b0, hold_v[1]}, 8'h00);
        chk("rst_ready", {7'b0, rdy_v[1]}, 8'h00);

        GO = 1; step(); GO = 0;
        chk("go_hold", {7'b0, hold_v[1]}, 8'h01);

        LD_START = 1; LD_ADDR = 16'h0100; step(); LD_START = 0;
        chk("ld_ready", {7'b0, rdy_v[1]}, 8'h01);
        chk("ld_hold", {7'b0, hold_v[1]}, 8'h00);
        send(8'h3E, 0);
        send(8'h55, 0);
        send(8'h76, 1);
        chk("last_hold", {7'b0, hold_v[1]}, 8'h01);
        chk("last_ready", {7'b0, rdy_v[1]}, 8'h00);
        A = 16'h0101; step(); A = 16'h0000; step();
        chk("rd_0101", di[1], 8'h55);

        LD_START = 1; LD_ADDR = 16'hFFFF; step(); LD_START = 0;
        send(8'h11, 0);
        send(8'h22, 0);
        send(8'h33, 1);
        A = 16'hFFFF; step();
        A = 16'h0000; step();
        chk("wrap_ffff", di[1], 8'h11);
        A = 16'h0001; step();
        chk("wrap_0000", di[1], 8'h22);
        A = 16'h0000; step();
        chk("wrap_0001", di[1], 8'h33);

        W = 1; A = 16'h2000; DO = 8'hA5; step(); W = 0; A = 16'h0000;
        chk("wf_L1", di[0], 8'hA5); step();
        chk("wf_L2", di[1], 8'hA5); step();
        chk("wf_L3", di[2], 8'hA5); step();
        chk("wf_L4", di[3], 8'hA5);

        LD_START = 1; LD_ADDR = 16'h0300; step(); LD_START = 0;
        W = 1; A = 16'h0100; DO = 8'hFF; step(); W = 0;
        step(); A = 16'h0000; step();
        chk("mask_0100", di[1], 8'h3E);
        send(8'h99, 1);

        LD_START = 1; LD_ADDR = 16'h0400; step(); LD_START = 0;
        send(8'hAA, 0);
        send(8'hBB, 0);
        RESET_N = 0; step(); RESET_N = 1;
        chk("mid_hold", {7'b0, hold_v[1]}, 8'h00);
        chk("mid_ready", {7'b0, rdy_v[1]}, 8'h00);
        chk("mid_di", di[1], 8'h00);
        A = 16'h0400; step(); A = 16'h0401; step();
        chk("keep_0400", di[1], 8'hAA);
        A = 16'h0000; step();
        chk("keep_0401", di[1], 8'hBB);

        LD_START = 1; GO = 1; LD_ADDR = 16'h0500; step(); LD_START = 0; GO = 0;
        chk("beat_ready", {7'b0, rdy_v[1]}, 8'h01);
        send(8'hC1, 0);
        send(8'hC2, 0);
        send(8'hC3, 0);
        send(8'hC4, 1);
        A = 16'h0503; step(); A = 16'h0000; step();
        chk("restart_0503", di[1], 8'hC4);

        for (int c = 0; c < 4000; c++) begin
            RESET_N  = ($urandom_range(0, 199) != 0);
            LD_START = ($urandom_range(0, 39) == 0);
            LD_ADDR  = pick();
            GO       = ($urandom_range(0, 19) == 0);
            LD_VALID = ($urandom_range(0, 9) < 6);
            LD_DATA  = 8'($urandom);
            LD_LAST  = ($urandom_range(0, 7) == 0);
            W        = ($urandom_range(0, 9) < 4);
            A        = pick();
            DO       = 8'($urandom);
            step();
        end
        idle();
        RESET_N = 1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/z80_memctl.md
# z80_memctl

Memory responder on the far end of the z80 CPU bus. Samples the CPU address, write strobe and write data every clock, keeps a byte-wide RAM, and returns read data on DI after a fixed pipeline latency. It also owns the CPU HOLD line and contains a streaming loader that fills RAM while the CPU is held, then releases the CPU.

## Interface
- ADDR_WIDTH, 16: RAM address bits. RAM holds 2^ADDR_WIDTH bytes. Upper A bits beyond ADDR_WIDTH are ignored.
- LATENCY, 2: cycles from A being sampled to the matching byte on DI. Legal range 1..4.

- CLOCK  in  1  system clock (100 MHz); all logic on posedge.
- RESET_N  in  1  reset, synchronous, active-low.
- A  in  16  CPU address.
- DO  in  8  CPU write data.
- W  in  1  CPU write strobe; writes DO to A at the sampling edge.
- DI  out  8  read data to the CPU.
- HOLD  out  1  1 lets the CPU run; 0 freezes it.
- LD_START  in  1  pulse that starts a load at LD_ADDR.
- LD_ADDR  in  16  start address of a load; captured on LD_START.
- LD_VALID  in  1  loader byte valid.
- LD_DATA  in  8  loader byte.
- LD_LAST  in  1  marks the final byte; qualified by LD_VALID.
- LD_READY  out  1  RAM accepts a loader byte this cycle.
- GO  in  1  pulse that releases the CPU without loading.

## Operation
- **States.**
  - HALTED: HOLD=0, LD_READY=0.
  - LOAD: HOLD=0, LD_READY=1.
  - RUN: HOLD=1, LD_READY=0.
  - Reset enters HALTED.
- **Transitions.**
  - HALTED or RUN + LD_START → LOAD. The pointer loads LD_ADDR[ADDR_WIDTH-1:0].
  - HALTED + GO → RUN.
  - LOAD + accepted byte with LD_LAST=1 → RUN.
  - LD_START beats GO when both are asserted in the same cycle.
  - GO is ignored in LOAD and RUN.
- **Loader handshake.**
  - A byte is accepted when LD_VALID and LD_READY are both 1.
  - An accepted byte is written to RAM[pointer], then the pointer increments modulo 2^ADDR_WIDTH (wraps to 0).
  - LD_START in LOAD restarts the load. A byte accepted in that same cycle is written at the old pointer, then the pointer reloads from LD_ADDR.
- **CPU writes.**
  - W=1 in RUN writes DO to RAM[A].
  - W is ignored in HALTED and LOAD, so the loader is the only writer while HOLD=0.
- **Reads.**
  - Every cycle, in every state, RAM[A] is read and enters a LATENCY-deep pipeline.
  - Reads are write-first: if a write (CPU or loader) hits the read address at the same edge, the pipeline receives the newly written byte.
- **Reset.**
  - Synchronous reset mid-load or mid-run: state goes to HALTED, the pointer clears to 0, and all pipeline stages clear to 0x00.
  - RAM contents are preserved across reset.

## Timing
- Reset values: DI=0x00, HOLD=0, LD_READY=0.
- HOLD and LD_READY are registered state decodes. They change one cycle after the triggering edge.
- Read latency: A sampled at edge t gives the byte on DI after edge t+LATENCY-1, valid during cycle t+LATENCY-1..t+LATENCY. With LATENCY=1, DI is the registered array output.
- A fully pipelined read can start every cycle; there are no bubbles.
- Writes are committed at the sampling edge. A read of the same address sampled at any later edge returns the new byte.
- Loader throughput: one byte per cycle while LD_VALID stays 1.
- Final byte (LD_LAST accepted at edge t): LD_READY=0 and HOLD=1 from cycle t+1.
- LD_START at edge t: LD_READY=1 and HOLD=0 from cycle t+1. The first byte can be accepted at edge t+1.
- Pipeline contents stay live across state changes. In-flight reads complete normally.

## Test plan
- **Reset:** hold RESET_N=0 for 3 cycles, then release → DI=0x00, HOLD=0, LD_READY=0. GO pulse → HOLD=1 next cycle.
- **Load then run:** LD_START with LD_ADDR=0x0100; stream 0x3E, 0x55, 0x76 with LD_LAST on 0x76 → HOLD rises the cycle after the last byte. A=0x0101 gives DI=0x55 after LATENCY cycles.
- **Wrap-around:** load 3 bytes from LD_ADDR=0xFFFF → RAM[0xFFFF], RAM[0x0000] and RAM[0x0001] hold them, in order.
- **Write-first and latency sweep:** in RUN, W=1, A=0x2000, DO=0xA5, with a read of 0x2000 the same cycle → DI=0xA5 after LATENCY cycles. Repeat for LATENCY=1..4.
- **CPU write masking:** in LOAD, CPU drives W=1, A=0x0100, DO=0xFF → RAM[0x0100] is unchanged.
- **Reset mid-load:** reset after 2 of 4 bytes → HALTED, HOLD=0, DI=0x00, and the two written bytes are retained. A new LD_START restarts cleanly.
